// File: rtl/vga_fb_pkg.sv
// Shared constants and grant encoding for the VGA frame-buffer arbiter.
// Covers the 640x480 RGB444 timing.
`timescale 1ns/1ps
package vga_fb_pkg;

    localparam int H_START  = 144;
    localparam int V_START  = 35;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_W0   = 2'd2,
        GNT_W1   = 2'd3
    } gnt_e;

endpackage

// File: rtl/vga_fb_scan_addr.sv
// Scan-out side: active-window decode, linear read address counter and the
// blanked pixel output register.
`timescale 1ns/1ps
module vga_fb_scan_addr #(
    parameter int H_START  = vga_fb_pkg::H_START,
    parameter int V_START  = vga_fb_pkg::V_START,
    parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_fb_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [15:0]       h_count,
    input  logic [15:0]       v_count,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              scan_req,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] pix_data
);

    // Reads run one pixel ahead of the visible window to cover RAM latency.
    localparam logic [15:0] H_PRE_FIRST = 16'(H_START - 1);
    localparam logic [15:0] H_PRE_LAST  = 16'(H_START + H_ACTIVE - 2);
    localparam logic [15:0] H_ACT_FIRST = 16'(H_START);
    localparam logic [15:0] H_ACT_LAST  = 16'(H_START + H_ACTIVE - 1);
    localparam logic [15:0] V_FIRST     = 16'(V_START);
    localparam logic [15:0] V_LAST      = 16'(V_START + V_ACTIVE - 1);

    logic v_act;
    logic h_pre;
    logic h_act;
    logic rd_vld_p0;

    assign v_act    = (v_count >= V_FIRST) && (v_count <= V_LAST);
    assign h_pre    = (h_count >= H_PRE_FIRST) && (h_count <= H_PRE_LAST);
    assign h_act    = (h_count >= H_ACT_FIRST) && (h_count <= H_ACT_LAST);
    assign scan_req = pix_en && v_act && h_pre;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_addr <= '0;
        end else if (pix_en && (v_count < V_FIRST)) begin
            scan_addr <= '0;
        end else if (scan_req) begin
            scan_addr <= scan_addr + ADDR_W'(1);
        end
    end

    // Stage p0: read issued last cycle, RAM data present this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_p0 <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_vld_p0 <= scan_req;
            if (pix_en && !(v_act && h_act)) begin
                pix_data <= '0;
            end else if (rd_vld_p0) begin
                pix_data <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out has fixed priority, two pixel
// writers share the remaining cycles round-robin.
`timescale 1ns/1ps
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int H_START  = vga_fb_pkg::H_START,
    parameter int V_START  = vga_fb_pkg::V_START,
    parameter int H_ACTIVE = vga_fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_fb_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic [15:0]       h_count,
    input  logic [15:0]       v_count,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              wr_oob
);

    localparam int FB_LIMIT = H_ACTIVE * V_ACTIVE;

    gnt_e              gnt;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              prefer_w1;
    logic              wr0_oob;
    logic              wr1_oob;
    logic [ADDR_W-1:0] addr_hold_p0;
    logic [DATA_W-1:0] wdata_hold_p0;

    vga_fb_scan_addr #(
        .H_START  (H_START),
        .V_START  (V_START),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_count   (h_count),
        .v_count   (v_count),
        .mem_rdata (mem_rdata),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .pix_data  (pix_data)
    );

    assign wr0_oob = (32'(wr0_addr) >= FB_LIMIT);
    assign wr1_oob = (32'(wr1_addr) >= FB_LIMIT);

    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (scan_req) begin
                gnt = GNT_SCAN;
            end else if (wr0_valid && wr1_valid) begin
                gnt = prefer_w1 ? GNT_W1 : GNT_W0;
            end else if (wr0_valid) begin
                gnt = GNT_W0;
            end else if (wr1_valid) begin
                gnt = GNT_W1;
            end
        end
    end

    // Out-of-range writes are granted and consumed but never reach the RAM.
    always_comb begin
        wr0_ready = (gnt == GNT_W0);
        wr1_ready = (gnt == GNT_W1);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_hold_p0;
        mem_wdata = wdata_hold_p0;
        case (gnt)
            GNT_SCAN: begin
                mem_en   = 1'b1;
                mem_addr = scan_addr;
            end
            GNT_W0: begin
                if (!wr0_oob) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr0_addr;
                    mem_wdata = wr0_data;
                end
            end
            GNT_W1: begin
                if (!wr1_oob) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wr1_addr;
                    mem_wdata = wr1_data;
                end
            end
            default: ;
        endcase
    end

    // Stage p0: remembered RAM address/data so idle cycles hold the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            prefer_w1     <= 1'b0;
            wr_oob        <= 1'b0;
            addr_hold_p0  <= '0;
            wdata_hold_p0 <= '0;
        end else begin
            addr_hold_p0  <= mem_addr;
            wdata_hold_p0 <= mem_wdata;
            if (gnt == GNT_W0) begin
                prefer_w1 <= 1'b1;
            end else if (gnt == GNT_W1) begin
                prefer_w1 <= 1'b0;
            end
            if (((gnt == GNT_W0) && wr0_oob) || ((gnt == GNT_W1) && wr1_oob)) begin
                wr_oob <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: reset, round-robin writes, scan
// priority, out-of-range writes and a partial-frame scan with a RAM model.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    logic        clk;
    logic        reset;
    logic        pix_en;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        wr0_valid;
    logic [18:0] wr0_addr;
    logic [11:0] wr0_data;
    logic        wr0_ready;
    logic        wr1_valid;
    logic [18:0] wr1_addr;
    logic [11:0] wr1_data;
    logic        wr1_ready;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic [11:0] pix_data;
    logic        wr_oob;

    int n_vec = 0;
    int n_err = 0;

    // RAM model stores the difference from a fixed address pattern.
    bit [11:0] ram [0:4095];

    logic        pend_read;
    logic        pend_blank;
    int          pend_addr;
    logic [11:0] exp_pix;

    vga_fb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_count   (h_count),
        .v_count   (v_count),
        .wr0_valid (wr0_valid),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr0_ready (wr0_ready),
        .wr1_valid (wr1_valid),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .wr1_ready (wr1_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .wr_oob    (wr_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input logic [18:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[11:0]] <= mem_wdata ^ pat(mem_addr);
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[11:0]] ^ pat(mem_addr);
    end

    // Only address 0 is rewritten inside the region the scan test reads.
    function automatic logic [11:0] exp_rd(input int a);
        return (a == 0) ? 12'hF00 : pat(19'(a));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cycle(input logic v0, input logic v1, input logic r0, input logic r1,
                            input logic en, input logic we, input logic [18:0] a);
        wr0_valid = v0;
        wr1_valid = v1;
        #2;
        chk("wr0_ready", 32'(wr0_ready), 32'(r0));
        chk("wr1_ready", 32'(wr1_ready), 32'(r1));
        chk("mem_en", 32'(mem_en), 32'(en));
        chk("mem_we", 32'(mem_we), 32'(we));
        if (en) chk("mem_addr", 32'(mem_addr), 32'(a));
        step();
    endtask

    // One pixel slot: pix_en for one cycle, then three idle cycles.
    task automatic pix(input int h, input int v);
        logic req;
        logic act;
        int   a;
        if (pend_read) exp_pix = exp_rd(pend_addr);
        else if (pend_blank) exp_pix = 12'h000;
        pix_en  = 1'b1;
        h_count = 16'(h);
        v_count = 16'(v);
        #2;
        chk("pix_data", 32'(pix_data), 32'(exp_pix));
        req = (v >= 35) && (v <= 514) && (h >= 143) && (h <= 782);
        act = (v >= 35) && (v <= 514) && (h >= 144) && (h <= 783);
        a   = (v - 35) * 640 + (h - 143);
        chk("scan_en", 32'(mem_en), 32'(req));
        if (req) chk("scan_addr", 32'(mem_addr), 32'(a));
        pend_read  = req;
        pend_addr  = a;
        pend_blank = !act;
        step();
        pix_en = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr0_ready"}, 32'(wr0_ready), 32'd0);
        chk({tag, ".wr1_ready"}, 32'(wr1_ready), 32'd0);
        chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ".pix_data"},  32'(pix_data),  32'd0);
        chk({tag, ".wr_oob"},    32'(wr_oob),    32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        pix_en    = 1'b0;
        h_count   = 16'd0;
        v_count   = 16'd0;
        wr0_valid = 1'b1;
        wr1_valid = 1'b1;
        wr0_addr  = 19'd2000;
        wr0_data  = 12'h111;
        wr1_addr  = 19'd2001;
        wr1_data  = 12'h222;
        pend_read  = 1'b0;
        pend_blank = 1'b1;
        pend_addr  = 0;
        exp_pix    = 12'h000;
        step();
        step();
        #2;
        chk_all_zero("reset");
        step();

        reset     = 1'b0;
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        pix_en    = 1'b1;
        v_count   = 16'd0;
        step();
        pix_en  = 1'b0;
        v_count = 16'd10;

        // Both writers in blanking alternate starting from W0.
        wr_cycle(1, 1, 1, 0, 1, 1, 19'd2000);
        wr_cycle(1, 1, 0, 1, 1, 1, 19'd2001);
        wr_cycle(1, 1, 1, 0, 1, 1, 19'd2000);
        wr_cycle(1, 1, 0, 1, 1, 1, 19'd2001);
        wr_cycle(0, 1, 0, 1, 1, 1, 19'd2001);
        wr_cycle(1, 0, 1, 0, 1, 1, 19'd2000);
        wr_cycle(0, 0, 0, 0, 0, 0, 19'd0);
        wr_cycle(1, 1, 0, 1, 1, 1, 19'd2001);
        wr1_valid = 1'b0;

        // Scan read beats a waiting writer, which lands one cycle later.
        wr0_addr  = 19'd2100;
        wr0_data  = 12'h333;
        wr0_valid = 1'b1;
        pix_en    = 1'b1;
        h_count   = 16'd200;
        v_count   = 16'd100;
        #2;
        chk("conflict.wr0_ready", 32'(wr0_ready), 32'd0);
        chk("conflict.mem_we", 32'(mem_we), 32'd0);
        chk("conflict.mem_en", 32'(mem_en), 32'd1);
        chk("conflict.mem_addr", 32'(mem_addr), 32'd0);
        step();
        pix_en = 1'b0;
        #2;
        chk("retry.wr0_ready", 32'(wr0_ready), 32'd1);
        chk("retry.mem_we", 32'(mem_we), 32'd1);
        chk("retry.mem_addr", 32'(mem_addr), 32'd2100);
        chk("retry.mem_wdata", 32'(mem_wdata), 32'h333);
        step();
        wr0_valid = 1'b0;
        #2;
        chk("idle.mem_en", 32'(mem_en), 32'd0);
        chk("idle.mem_addr", 32'(mem_addr), 32'd2100);
        chk("idle.mem_wdata", 32'(mem_wdata), 32'h333);
        step();

        // Pixel 0 rewritten in vertical blanking, which also rewinds the scan.
        wr0_addr  = 19'd0;
        wr0_data  = 12'hF00;
        wr0_valid = 1'b1;
        pix_en    = 1'b1;
        h_count   = 16'd0;
        v_count   = 16'd20;
        #2;
        chk("wr_px0.wr0_ready", 32'(wr0_ready), 32'd1);
        chk("wr_px0.mem_we", 32'(mem_we), 32'd1);
        chk("wr_px0.mem_wdata", 32'(mem_wdata), 32'hF00);
        step();
        pix_en = 1'b0;

        // Last in-range address, then the first out-of-range one.
        wr0_addr = 19'd307199;
        wr0_data = 12'h0AB;
        #2;
        chk("last.mem_en", 32'(mem_en), 32'd1);
        chk("last.mem_addr", 32'(mem_addr), 32'd307199);
        step();
        wr0_valid = 1'b0;
        #2;
        chk("last.wr_oob", 32'(wr_oob), 32'd0);
        wr1_addr  = 19'd307200;
        wr1_data  = 12'hFFF;
        wr1_valid = 1'b1;
        #1;
        chk("oob.wr1_ready", 32'(wr1_ready), 32'd1);
        chk("oob.mem_en", 32'(mem_en), 32'd0);
        chk("oob.mem_we", 32'(mem_we), 32'd0);
        step();
        wr1_valid = 1'b0;
        #2;
        chk("oob.wr_oob", 32'(wr_oob), 32'd1);
        wr0_addr  = 19'd3000;
        wr0_data  = 12'h456;
        wr0_valid = 1'b1;
        step();
        wr0_valid = 1'b0;
        step();
        step();
        #2;
        chk("oob.sticky", 32'(wr_oob), 32'd1);
        step();

        // Top of the next frame: two active lines plus the line before.
        for (int v = 34; v <= 36; v++) begin
            for (int h = 140; h <= 786; h++) begin
                pix(h, v);
            end
        end
        #2;
        chk("oob.held", 32'(wr_oob), 32'd1);

        // Reset in the middle of active video with both writers pending.
        reset     = 1'b1;
        wr0_valid = 1'b1;
        wr1_valid = 1'b1;
        pix_en    = 1'b1;
        h_count   = 16'd300;
        v_count   = 16'd36;
        #1;
        chk("rst.wr0_ready", 32'(wr0_ready), 32'd0);
        chk("rst.wr1_ready", 32'(wr1_ready), 32'd0);
        chk("rst.mem_en", 32'(mem_en), 32'd0);
        step();
        #2;
        chk_all_zero("rst_mid");
        step();
        reset  = 1'b0;
        pix_en = 1'b0;
        #2;
        chk("rst_rr.wr0_ready", 32'(wr0_ready), 32'd1);
        chk("rst_rr.wr1_ready", 32'(wr1_ready), 32'd0);
        step();
        wr0_valid  = 1'b0;
        wr1_valid  = 1'b0;
        pend_read  = 1'b0;
        pend_blank = 1'b1;
        exp_pix    = 12'h000;
        pix(0, 0);
        pix(142, 35);
        pix(143, 35);
        pix(144, 35);
        pix(145, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
